// File: rtl/bus_demux4.sv
// bus_demux4: routes one load/store request to one of four targets (RAM, UART,
// GPIO, timer) using the top two address bits, returns the selected target's
// completion, and converts a silent target into a timeout error response.
// Only one transaction is outstanding at a time. Every output is driven from
// a flop, so no input has a combinational path to any output.
module bus_demux4 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  // initiator request
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_addr,
  input  logic               req_we,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  // target request side (payload shared, strobe one-hot)
  output logic [3:0]         t_valid,
  output logic [AW-1:0]      t_addr,
  output logic               t_we,
  output logic [WIDTH-1:0]   t_wdata,
  output logic [WIDTH/8-1:0] t_be,
  input  logic [3:0]         t_ready,
  // target completion side
  input  logic [3:0]         t_rvalid,
  input  logic [WIDTH-1:0]   t_rdata0,
  input  logic [WIDTH-1:0]   t_rdata1,
  input  logic [WIDTH-1:0]   t_rdata2,
  input  logic [WIDTH-1:0]   t_rdata3,
  // initiator response
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  input  logic               rsp_ready
);

  localparam int unsigned BW = WIDTH / 8;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  logic [AW-1:0]    addr_d;
  logic             we_d;
  logic [WIDTH-1:0] wdata_d;
  logic [BW-1:0]    be_d;

  logic [3:0]       t_valid_d;
  logic             req_ready_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_d;
  logic             rsp_err_d;

  logic [WIDTH-1:0] sel_rdata;
  logic             timeout;

  // Read data of the currently selected target.
  always_comb begin
    sel_rdata = '0;
    unique case (sel_q)
      2'd0:    sel_rdata = t_rdata0;
      2'd1:    sel_rdata = t_rdata1;
      2'd2:    sel_rdata = t_rdata2;
      default: sel_rdata = t_rdata3;
    endcase
  end

  // Last cycle the transaction may spend in REQ+WAIT.
  assign timeout = (cnt_q == CNT_LAST);

  // Next state, latched fields and next output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    addr_d      = t_addr;
    we_d        = t_we;
    wdata_d     = t_wdata;
    be_d        = t_be;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    t_valid_d   = 4'b0000;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // req_ready is a flop; acceptance follows exactly what was advertised
        if (req_ready && req_valid) begin
          state_d     = REQ;
          cnt_d       = '0;
          sel_d       = req_addr[AW-1 -: 2];
          addr_d      = req_addr;
          we_d        = req_we;
          wdata_d     = req_wdata;
          be_d        = req_be;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        // an accept landing in the timeout cycle is still reported as an error
        if (timeout) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (t_ready[sel_q]) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // completion takes priority over a coincident timeout
        if (t_rvalid[sel_q]) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = t_we ? '0 : sel_rdata;
        end else if (timeout) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == REQ) begin
      t_valid_d = 4'b0001 << sel_d;
    end
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State, counter, latched fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      t_addr    <= '0;
      t_we      <= 1'b0;
      t_wdata   <= '0;
      t_be      <= '0;
      t_valid   <= 4'b0000;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      t_addr    <= addr_d;
      t_we      <= we_d;
      t_wdata   <= wdata_d;
      t_be      <= be_d;
      t_valid   <= t_valid_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_bus_demux4.sv
// Self-checking bench for bus_demux4: expected responses are queued when a
// request is issued and compared when the router presents its response.
module tb_bus_demux4;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned BW      = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic             req_we = 1'b0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic [BW-1:0]    req_be = '0;
  logic [3:0]       t_valid;
  logic [AW-1:0]    t_addr;
  logic             t_we;
  logic [WIDTH-1:0] t_wdata;
  logic [BW-1:0]    t_be;
  logic [3:0]       t_ready = 4'b0000;
  logic [3:0]       t_rvalid = 4'b0000;
  logic [WIDTH-1:0] t_rdata0 = '0;
  logic [WIDTH-1:0] t_rdata1 = '0;
  logic [WIDTH-1:0] t_rdata2 = '0;
  logic [WIDTH-1:0] t_rdata3 = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             rsp_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [WIDTH:0] sb_q[$];   // {err, rdata}

  always #5 clk = ~clk;

  bus_demux4 #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .t_valid(t_valid), .t_addr(t_addr), .t_we(t_we), .t_wdata(t_wdata), .t_be(t_be),
    .t_ready(t_ready), .t_rvalid(t_rvalid),
    .t_rdata0(t_rdata0), .t_rdata1(t_rdata1), .t_rdata2(t_rdata2), .t_rdata3(t_rdata3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic do_req(input string tag, input logic [AW-1:0] addr, input logic we,
                        input logic [WIDTH-1:0] wdata, input logic [BW-1:0] be,
                        input logic push, input logic [WIDTH:0] exp);
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    if (push) sb_q.push_back(exp);
    step();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, handshake.
  task automatic collect_rsp(input string tag, input int exp_wait);
    int n = 0;
    logic [WIDTH:0] exp;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_rsp_latency"}, 64'(n), 64'(exp_wait));
    if (!rsp_valid) return;
    check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_rsp"}, 64'({rsp_err, rsp_rdata}), 64'(exp));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_t_valid", 64'(t_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_t_addr", 64'(t_addr), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // read from target 2, best-case latency
    do_req("rd2", 32'h8000_0010, 1'b0, '0, 4'hF, 1'b1, {1'b0, 32'hDEAD_BEEF});
    check("rd2_t_valid_c1", 64'(t_valid), 64'b0100);
    check("rd2_t_addr", 64'(t_addr), 64'h8000_0010);
    check("rd2_t_we", 64'(t_we), 64'd0);
    t_ready = 4'b0100;
    step();
    t_ready = 4'b0000;
    check("rd2_t_valid_c2", 64'(t_valid), 64'd0);
    t_rvalid = 4'b0100;
    t_rdata2 = 32'hDEAD_BEEF;
    step();
    t_rvalid = 4'b0000;
    collect_rsp("rd2", 0);

    // write to target 0 with a slow accept; read data must not leak into the response
    do_req("wr0", 32'h0000_0004, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, {1'b0, 32'h0});
    for (int c = 1; c <= 4; c++) begin
      check("wr0_t_valid", 64'(t_valid), 64'b0001);
      check("wr0_t_wdata", 64'(t_wdata), 64'h1234_5678);
      check("wr0_t_be", 64'(t_be), 64'b0011);
      t_ready = (c == 4) ? 4'b0001 : 4'b0000;
      step();
    end
    t_ready  = 4'b0000;
    t_rvalid = 4'b0001;
    t_rdata0 = 32'hFFFF_FFFF;
    step();
    t_rvalid = 4'b0000;
    collect_rsp("wr0", 0);

    // timeout on target 3 with stray activity from target 1
    do_req("to3", 32'hC000_0000, 1'b0, '0, 4'hF, 1'b1, {1'b1, 32'h0});
    for (int c = 1; c <= 16; c++) begin
      check("to3_t_valid", 64'(t_valid), (c <= 15) ? 64'b1000 : 64'd0);
      check("to3_rsp_valid", 64'(rsp_valid), (c == 16) ? 64'd1 : 64'd0);
      t_ready  = (c == 3) ? 4'b0010 : 4'b0000;
      t_rvalid = (c == 5) ? 4'b0010 : 4'b0000;
      t_rdata1 = 32'h1111_1111;
      if (c < 16) step();
    end
    t_ready  = 4'b0000;
    t_rvalid = 4'b0000;
    collect_rsp("to3", 0);

    // response backpressure with the next request already waiting
    do_req("bp1", 32'h4000_0008, 1'b0, '0, 4'hF, 1'b1, {1'b0, 32'hA5A5_0001});
    t_ready = 4'b0010;
    step();
    t_ready  = 4'b0000;
    t_rvalid = 4'b0010;
    t_rdata1 = 32'hA5A5_0001;
    step();
    t_rvalid  = 4'b0000;
    t_rdata1  = 32'h0;
    req_addr  = 32'hC000_0004;
    req_we    = 1'b0;
    req_valid = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      check("bp1_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp1_rsp_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
      check("bp1_rsp_err", 64'(rsp_err), 64'd0);
      check("bp1_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    check("bp1_no_accept", 64'(t_valid), 64'd0);
    collect_rsp("bp1", 0);
    sb_q.push_back({1'b0, 32'h0BAD_F00D});
    step();
    req_valid = 1'b0;
    check("bp2_t_valid", 64'(t_valid), 64'b1000);
    check("bp2_t_addr", 64'(t_addr), 64'hC000_0004);
    t_ready = 4'b1000;
    step();
    t_ready  = 4'b0000;
    t_rvalid = 4'b1000;
    t_rdata3 = 32'h0BAD_F00D;
    step();
    t_rvalid = 4'b0000;
    collect_rsp("bp2", 0);

    // completion in the timeout cycle wins
    do_req("cmp1", 32'h4000_0000, 1'b0, '0, 4'hF, 1'b1, {1'b0, 32'h5555_AAAA});
    for (int c = 1; c <= 15; c++) begin
      t_ready  = (c == 2) ? 4'b0010 : 4'b0000;
      t_rvalid = (c == 15) ? 4'b0010 : 4'b0000;
      t_rdata1 = 32'h5555_AAAA;
      step();
    end
    t_rvalid = 4'b0000;
    collect_rsp("cmp1", 0);

    // accept in the timeout cycle is still an error
    do_req("to2", 32'h8000_0000, 1'b0, '0, 4'hF, 1'b1, {1'b1, 32'h0});
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) check("to2_t_valid_last", 64'(t_valid), 64'b0100);
      t_ready = (c == 15) ? 4'b0100 : 4'b0000;
      step();
    end
    t_ready = 4'b0000;
    collect_rsp("to2", 0);

    // asynchronous reset mid-WAIT drops the transaction
    do_req("rst0", 32'h0000_0020, 1'b0, 32'hFFFF_0000, 4'hF, 1'b0, '0);
    t_ready = 4'b0001;
    step();
    t_ready = 4'b0000;
    step();
    check("rst0_t_addr_before", 64'(t_addr), 64'h0000_0020);
    #2 reset = 1'b1;
    #1;
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_t_valid", 64'(t_valid), 64'd0);
    check("arst_t_addr", 64'(t_addr), 64'd0);
    check("arst_t_we_wdata_be", 64'({t_we, t_wdata, t_be}), 64'd0);
    check("arst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("arst_release_ready", 64'(req_ready), 64'd1);
    check("arst_no_rsp", 64'(rsp_valid), 64'd0);
    do_req("rd0", 32'h0000_0040, 1'b0, '0, 4'hF, 1'b1, {1'b0, 32'h1357_9BDF});
    check("rd0_t_valid", 64'(t_valid), 64'b0001);
    t_ready = 4'b0001;
    step();
    t_ready  = 4'b0000;
    t_rvalid = 4'b0001;
    t_rdata0 = 32'h1357_9BDF;
    step();
    t_rvalid = 4'b0000;
    collect_rsp("rd0", 0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_demux4.md
# bus_demux4

Single-initiator, four-target request router for the core's data-memory port. One request from the load/store unit is steered to one of four targets (RAM, UART, GPIO, timer) by the top two address bits. The selected target's read data and completion are routed back to the initiator. A per-transaction timeout returns an error when a target never answers. One transaction is outstanding at a time, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32, data width; must be a multiple of 8
- AW, 32, address width; must be at least 3
- TIMEOUT, 15, cycles allowed in REQ+WAIT before an error response; must be at least 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  initiator request valid
- req_ready  out  1  router can accept a request
- req_addr  in  AW  request address; bits [AW-1:AW-2] select the target
- req_we  in  1  1 = write, 0 = read
- req_wdata  in  WIDTH  write data
- req_be  in  WIDTH/8  byte enables
- t_valid  out  4  one-hot request strobe to targets 0..3
- t_addr  out  AW  latched address, shared by all targets
- t_we  out  1  latched write enable, shared
- t_wdata  out  WIDTH  latched write data, shared
- t_be  out  WIDTH/8  latched byte enables, shared
- t_ready  in  4  per-target request accept
- t_rvalid  in  4  per-target completion pulse, for reads and writes
- t_rdata0..t_rdata3  in  WIDTH each  per-target read data, valid with t_rvalid
- rsp_valid  out  1  response to initiator valid
- rsp_rdata  out  WIDTH  response read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout error
- rsp_ready  in  1  initiator accepts the response

## Operation
FSM states are IDLE, REQ, WAIT and RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch addr, we, wdata and be, and set sel=req_addr[AW-1:AW-2]. Go to REQ with the timeout counter cleared to 0.
- **REQ:**
  - t_valid[sel]=1; all other t_valid bits are 0.
  - t_addr, t_we, t_wdata and t_be hold the latched values.
  - On t_ready[sel], go to WAIT. t_rvalid is not sampled in REQ.
- **WAIT:**
  - t_valid=0.
  - On t_rvalid[sel], capture rsp_rdata as t_rdata[sel] for a read or 0 for a write, set rsp_err=0, and go to RESP.
- **RESP:**
  - rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- **Timeout:**
  - The counter increments every cycle spent in REQ or WAIT.
  - In a cycle where counter==TIMEOUT-1 and the normal exit does not occur, go to RESP with rsp_err=1 and rsp_rdata=0. t_valid drops immediately.
  - If completion (t_rvalid[sel] in WAIT) and timeout happen in the same cycle, completion wins and rsp_err=0.
  - If t_ready[sel] arrives in REQ in the timeout cycle, the result is still an error.
  - Counter width is $clog2(TIMEOUT+1).
- **Unselected targets:** t_ready and t_rvalid bits from unselected targets are ignored in every state.
- **Target contract:** a target must not assert t_rvalid for a request that was aborted by timeout.
- **Reset:**
  - Asynchronous reset in any state forces IDLE, clears the counter and latched fields, and zeroes all outputs.
  - req_ready is 0 while reset is high and becomes 1 on the first cycle after deassertion.
  - A transaction in flight is dropped with no response.

## Timing
- Outputs after reset: req_ready=1 once reset is low; t_valid=0, t_addr=0, t_we=0, t_wdata=0, t_be=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All outputs are functions of registered state and latched fields only. There is no combinational path from any input to any output.
- Best-case latency, with request accepted in cycle 0:
  - t_valid high in cycle 1.
  - With t_ready in cycle 1, the FSM is in WAIT in cycle 2.
  - With t_rvalid in cycle 2, rsp_valid is high in cycle 3.
- Throughput: the earliest next acceptance is the cycle after the rsp_valid&rsp_ready handshake. The best case is one transaction every 4 cycles.
- Timeout: with no target activity after acceptance in cycle 0, rsp_valid with rsp_err=1 rises in cycle TIMEOUT+1.

## Test plan
- Read from target 2: req_addr=0x8000_0010, t_ready[2] in cycle 1, t_rvalid[2] in cycle 2 with t_rdata2=0xDEADBEEF -> rsp_valid in cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0; t_valid=4'b0100 only in cycle 1.
- Write to target 0: req_addr=0x0000_0004, wdata=0x1234_5678, be=4'b0011, t_ready delayed 3 cycles -> t_valid[0] held with stable t_wdata and t_be; response has rsp_rdata=0 and rsp_err=0.
- Timeout, TIMEOUT=15, target 3 never responds -> t_valid[3] high for 15 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0 in cycle 16; a stray t_rvalid[1] during the wait is ignored.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready stays 0, and the next request is accepted the cycle after rsp_ready.
- Same-cycle completion and timeout: t_rvalid[sel] in the timeout cycle -> rsp_err=0 with correct data.
- Reset asserted asynchronously mid-WAIT -> all outputs return to 0 immediately, req_ready=1 after release, and a fresh read completes normally.
